smii_phy_end: RTL and testbench

SMII_PHY_END -- requirements
Module: smii_phy_end

---
 rtl/smii_phy_end.sv | 150 +++++++++++++++
 tb/tb_smii_phy_end.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smii_phy_end.sv
`default_nettype none
// ============================================================================
// Module   : smii_phy_end
// Brief    : PHY-side SMII segment engine: TX segment decode, RX segment
//            generation with 10M repetition, sync alignment tracking.
// Revision : 1.0 - initial release
// ============================================================================
module smii_phy_end (
    input  logic       smii_ref_clk,
    input  logic       rst,
    input  logic       cfg_speed,
    input  logic       cfg_duplex,
    input  logic       cfg_link,
    input  logic       smii_sync,
    input  logic       smii_txd,
    output logic       smii_rxd,
    output logic       locked,
    output logic       sync_err,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_err,
    output logic       tx_frame,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_crs,
    output logic       rx_ready
);

    localparam logic [3:0] LAST_BIT = 4'd9;
    localparam logic [3:0] LAST_SEG = 4'd9;

    logic       sync_q, txd_q;
    logic       locked_q, locked_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] seg_cnt_q, seg_cnt_d;
    logic       speed_q, speed_d;
    logic [8:0] tx_sreg_q, tx_sreg_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_err_q, tx_err_d;
    logic       tx_frame_q, tx_frame_d;
    logic       sync_err_q, sync_err_d;
    logic [9:0] rx_seg_q, rx_seg_d;
    logic       rxd_q, rxd_d;

    logic       seg_wrap;
    logic       decode;
    logic       load;

    // bit_cnt_d is the segment position of the bit currently held in txd_q
    always_comb begin
        seg_wrap   = (bit_cnt_q == LAST_BIT);
        bit_cnt_d  = (sync_q || seg_wrap) ? 4'd0 : bit_cnt_q + 4'd1;
        locked_d   = locked_q | sync_q;
        sync_err_d = sync_q & locked_q & ~seg_wrap;

        speed_d   = speed_q;
        seg_cnt_d = seg_cnt_q;
        if (seg_wrap) begin
            speed_d = cfg_speed;
            if (cfg_speed || speed_q) begin
                seg_cnt_d = 4'd0;
            end else begin
                seg_cnt_d = (seg_cnt_q == LAST_SEG) ? 4'd0 : seg_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        tx_sreg_d = tx_sreg_q;
        for (int i = 0; i < 9; i++) begin
            if (bit_cnt_d == i[3:0]) begin
                tx_sreg_d[i] = txd_q;
            end
        end

        decode     = locked_q & (bit_cnt_d == LAST_BIT) & (seg_cnt_q == 4'd0);
        tx_valid_d = decode & tx_sreg_q[1];
        tx_data_d  = tx_data_q;
        tx_err_d   = tx_err_q;
        tx_frame_d = tx_frame_q;
        if (decode) begin
            tx_frame_d = tx_sreg_q[1];
            if (tx_sreg_q[1]) begin
                tx_data_d = {txd_q, tx_sreg_q[8:2]};
                tx_err_d  = tx_sreg_q[0];
            end
        end
    end

    assign load     = ~rst & locked_q & seg_wrap & (speed_q | (seg_cnt_q == LAST_SEG));
    assign rx_ready = load;

    // Status segment: {1, FC=0, UNV=0, JAB=0, link, duplex, speed, RXER=0, DV=0, CRS}
    always_comb begin
        rx_seg_d = rx_seg_q;
        if (load) begin
            if (rx_valid) begin
                rx_seg_d = {rx_data, 1'b1, rx_crs};
            end else begin
                rx_seg_d = {1'b1, 3'b000, cfg_link, cfg_duplex, cfg_speed, 1'b0, 1'b0, rx_crs};
            end
        end
        rxd_d = locked_q ? rx_seg_d[bit_cnt_d] : 1'b0;
    end

    always_ff @(posedge smii_ref_clk) begin
        if (rst) begin
            sync_q     <= 1'b0;
            txd_q      <= 1'b0;
            locked_q   <= 1'b0;
            bit_cnt_q  <= 4'd0;
            seg_cnt_q  <= 4'd0;
            speed_q    <= 1'b0;
            tx_sreg_q  <= 9'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_err_q   <= 1'b0;
            tx_frame_q <= 1'b0;
            sync_err_q <= 1'b0;
            rx_seg_q   <= 10'd0;
            rxd_q      <= 1'b0;
        end else begin
            sync_q     <= smii_sync;
            txd_q      <= smii_txd;
            locked_q   <= locked_d;
            bit_cnt_q  <= bit_cnt_d;
            seg_cnt_q  <= seg_cnt_d;
            speed_q    <= speed_d;
            tx_sreg_q  <= tx_sreg_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_err_q   <= tx_err_d;
            tx_frame_q <= tx_frame_d;
            sync_err_q <= sync_err_d;
            rx_seg_q   <= rx_seg_d;
            rxd_q      <= rxd_d;
        end
    end

    assign smii_rxd = rxd_q;
    assign locked   = locked_q;
    assign sync_err = sync_err_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_err   = tx_err_q;
    assign tx_frame = tx_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_smii_phy_end.sv
`default_nettype none
// ============================================================================
// Module   : tb_smii_phy_end
// Brief    : Directed self-checking bench for smii_phy_end.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_smii_phy_end;

    logic       smii_ref_clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_speed = 1'b1, cfg_duplex = 1'b1, cfg_link = 1'b1;
    logic       smii_sync = 1'b0, smii_txd = 1'b0;
    logic       smii_rxd, locked, sync_err, tx_valid, tx_err, tx_frame, rx_ready;
    logic [7:0] tx_data;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_crs = 1'b0;

    int total = 0;
    int bad   = 0;

    smii_phy_end dut (
        .smii_ref_clk(smii_ref_clk), .rst(rst),
        .cfg_speed(cfg_speed), .cfg_duplex(cfg_duplex), .cfg_link(cfg_link),
        .smii_sync(smii_sync), .smii_txd(smii_txd), .smii_rxd(smii_rxd),
        .locked(locked), .sync_err(sync_err),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_err(tx_err), .tx_frame(tx_frame),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_crs(rx_crs), .rx_ready(rx_ready)
    );

    always #4 smii_ref_clk = ~smii_ref_clk;

    // Event log sampled mid-cycle; RX segment captured over the 10 cycles after each rx_ready
    int         cyc = 0;
    int         tv_cnt = 0, tv_last_time = 0, tv_gap = 0;
    logic [7:0] tv_hist[$];
    logic       tv_last_err = 1'b0;
    int         se_cnt = 0;
    int         rr_cnt = 0, rr_last_time = 0, rr_gap = 0, rr_double = 0;
    logic       rr_prev = 1'b0;
    int         cap_idx = 10;
    logic [9:0] cap = 10'd0;
    logic       cap_dv = 1'b0;
    logic [9:0] last_data_seg = 10'd0, last_status_seg = 10'd0;
    int         data_seg_cnt = 0, status_seg_cnt = 0;

    always @(negedge smii_ref_clk) begin
        cyc++;
        if (tx_valid) begin
            tv_cnt++;
            tv_hist.push_back(tx_data);
            tv_last_err  = tx_err;
            tv_gap       = cyc - tv_last_time;
            tv_last_time = cyc;
        end
        if (sync_err) se_cnt++;
        if (cap_idx < 10) begin
            cap[cap_idx] = smii_rxd;
            cap_idx++;
            if (cap_idx == 10) begin
                if (cap_dv) begin
                    last_data_seg = cap;
                    data_seg_cnt++;
                end else begin
                    last_status_seg = cap;
                    status_seg_cnt++;
                end
            end
        end
        if (rx_ready) begin
            rr_cnt++;
            rr_gap       = cyc - rr_last_time;
            rr_last_time = cyc;
            if (rr_prev) rr_double++;
            cap_idx = 0;
            cap_dv  = rx_valid;
        end
        rr_prev = rx_ready;
    end

    task automatic tick();
        logic take;
        take = rx_valid && rx_ready;
        @(posedge smii_ref_clk);
        #1;
        if (take) rx_valid = 1'b0;
    endtask

    function automatic logic [9:0] txseg(input logic [7:0] d, input logic en, input logic er);
        return {d, en, er};
    endfunction

    task automatic send_seg(input logic [9:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            smii_sync = (i == 0);
            smii_txd  = s[i];
            tick();
        end
        smii_sync = 1'b0;
        smii_txd  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smii_sync = i[0];
            smii_txd  = ~i[0];
            tick();
        end
        total++; if (locked   !== 1'b0)  begin bad++; $display("FAIL rst_locked got %b want 0", locked); end
        total++; if (sync_err !== 1'b0)  begin bad++; $display("FAIL rst_sync_err got %b want 0", sync_err); end
        total++; if (smii_rxd !== 1'b0)  begin bad++; $display("FAIL rst_rxd got %b want 0", smii_rxd); end
        total++; if (tx_valid !== 1'b0)  begin bad++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
        total++; if (tx_data  !== 8'h00) begin bad++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        total++; if (tx_err   !== 1'b0)  begin bad++; $display("FAIL rst_tx_err got %b want 0", tx_err); end
        total++; if (tx_frame !== 1'b0)  begin bad++; $display("FAIL rst_tx_frame got %b want 0", tx_frame); end
        total++; if (rx_ready !== 1'b0)  begin bad++; $display("FAIL rst_rx_ready got %b want 0", rx_ready); end
        rst = 1'b0;
        smii_sync = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        total++; if (locked   !== 1'b0) begin bad++; $display("FAIL nosync_locked got %b want 0", locked); end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL nosync_rx_ready got %b want 0", rx_ready); end
    endtask

    task automatic test_idle_segment();
        int tb0, se0;
        tb0 = tv_cnt; se0 = se_cnt;
        for (int k = 0; k < 4; k++) send_seg(10'h1A5, 10);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL idle_locked got %b want 1", locked); end
        total++; if (tv_cnt - tb0 !== 0) begin bad++; $display("FAIL idle_tx_valid got %0d want 0", tv_cnt - tb0); end
        total++; if (tx_frame !== 1'b0) begin bad++; $display("FAIL idle_tx_frame got %b want 0", tx_frame); end
        total++; if (se_cnt - se0 !== 0) begin bad++; $display("FAIL idle_sync_err got %0d want 0", se_cnt - se0); end
    endtask

    task automatic test_tx_data();
        int b;
        logic [7:0] d0, d1;
        b = tv_cnt;
        send_seg(txseg(8'h3C, 1'b1, 1'b0), 10);
        send_seg(txseg(8'hD5, 1'b1, 1'b0), 10);
        send_seg(10'h000, 10);
        total++; if (tx_frame !== 1'b1) begin bad++; $display("FAIL tx_frame_active got %b want 1", tx_frame); end
        send_seg(10'h000, 10);
        total++; if (tx_frame !== 1'b0) begin bad++; $display("FAIL tx_frame_idle got %b want 0", tx_frame); end
        d0 = (tv_hist.size() > b)     ? tv_hist[b]     : 8'hxx;
        d1 = (tv_hist.size() > b + 1) ? tv_hist[b + 1] : 8'hxx;
        total++; if (tv_cnt - b !== 2) begin bad++; $display("FAIL tx_pulses got %0d want 2", tv_cnt - b); end
        total++; if (d0 !== 8'h3C) begin bad++; $display("FAIL tx_byte0 got %h want 3c", d0); end
        total++; if (d1 !== 8'hD5) begin bad++; $display("FAIL tx_byte1 got %h want d5", d1); end
        total++; if (tv_gap !== 10) begin bad++; $display("FAIL tx_spacing got %0d want 10", tv_gap); end
        total++; if (tv_last_err !== 1'b0) begin bad++; $display("FAIL tx_err_clear got %b want 0", tv_last_err); end
        send_seg(txseg(8'h5A, 1'b1, 1'b1), 10);
        send_seg(10'h000, 10);
        total++; if (tv_cnt - b !== 3) begin bad++; $display("FAIL tx_er_pulses got %0d want 3", tv_cnt - b); end
        total++; if (tx_data !== 8'h5A) begin bad++; $display("FAIL tx_er_byte got %h want 5a", tx_data); end
        total++; if (tv_last_err !== 1'b1) begin bad++; $display("FAIL tx_err_set got %b want 1", tv_last_err); end
    endtask

    task automatic test_rx_data();
        int d0;
        d0 = data_seg_cnt;
        rx_crs   = 1'b1;
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        for (int k = 0; k < 4; k++) send_seg(10'h000, 10);
        total++; if (data_seg_cnt - d0 !== 1) begin bad++; $display("FAIL rx_loads got %0d want 1", data_seg_cnt - d0); end
        total++; if (last_data_seg !== 10'h157) begin bad++; $display("FAIL rx_data_seg got %h want 157", last_data_seg); end
        total++; if (rr_double !== 0) begin bad++; $display("FAIL rx_ready_width got %0d want 0", rr_double); end
        total++; if (rr_gap !== 10) begin bad++; $display("FAIL rx_ready_gap_100m got %0d want 10", rr_gap); end
    endtask

    task automatic test_rx_status();
        cfg_speed = 1'b1; cfg_duplex = 1'b1; cfg_link = 1'b1; rx_crs = 1'b0;
        for (int k = 0; k < 3; k++) send_seg(10'h000, 10);
        total++; if (last_status_seg !== 10'h238) begin bad++; $display("FAIL rx_status_fdx got %h want 238", last_status_seg); end
        cfg_duplex = 1'b0; cfg_link = 1'b0; rx_crs = 1'b1;
        for (int k = 0; k < 3; k++) send_seg(10'h000, 10);
        total++; if (last_status_seg !== 10'h209) begin bad++; $display("FAIL rx_status_down got %h want 209", last_status_seg); end
    endtask

    task automatic test_10m();
        int b;
        cfg_speed = 1'b0; cfg_duplex = 1'b1; cfg_link = 1'b1; rx_crs = 1'b0;
        for (int k = 0; k < 12; k++) send_seg(10'h000, 10);
        b = tv_cnt;
        for (int k = 0; k < 10; k++) send_seg(txseg(8'hA7, 1'b1, 1'b0), 10);
        for (int k = 0; k < 11; k++) send_seg(10'h000, 10);
        total++; if (tv_cnt - b !== 1) begin bad++; $display("FAIL m10_tx_pulses got %0d want 1", tv_cnt - b); end
        total++; if (tx_data !== 8'hA7) begin bad++; $display("FAIL m10_tx_byte got %h want a7", tx_data); end
        total++; if (rr_gap !== 100) begin bad++; $display("FAIL m10_rx_ready_gap got %0d want 100", rr_gap); end
        total++; if (last_status_seg !== 10'h230) begin bad++; $display("FAIL m10_status got %h want 230", last_status_seg); end
    endtask

    task automatic test_misalign();
        int b, s;
        cfg_speed = 1'b1;
        for (int k = 0; k < 3; k++) send_seg(10'h000, 10);
        b = tv_cnt; s = se_cnt;
        send_seg(txseg(8'h11, 1'b1, 1'b0), 5);
        send_seg(txseg(8'h9E, 1'b1, 1'b0), 10);
        send_seg(10'h000, 10);
        total++; if (se_cnt - s !== 1) begin bad++; $display("FAIL misalign_sync_err got %0d want 1", se_cnt - s); end
        total++; if (tv_cnt - b !== 1) begin bad++; $display("FAIL misalign_tx_pulses got %0d want 1", tv_cnt - b); end
        total++; if (tx_data !== 8'h9E) begin bad++; $display("FAIL misalign_tx_byte got %h want 9e", tx_data); end
    endtask

    task automatic test_reset_mid_frame();
        int b;
        logic idle_bad;
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        send_seg(txseg(8'hC3, 1'b1, 1'b0), 5);
        rst = 1'b1;
        smii_txd = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++; if (locked   !== 1'b0)  begin bad++; $display("FAIL midrst_locked got %b want 0", locked); end
        total++; if (tx_data  !== 8'h00) begin bad++; $display("FAIL midrst_tx_data got %h want 00", tx_data); end
        total++; if (tx_frame !== 1'b0)  begin bad++; $display("FAIL midrst_tx_frame got %b want 0", tx_frame); end
        total++; if (smii_rxd !== 1'b0)  begin bad++; $display("FAIL midrst_rxd got %b want 0", smii_rxd); end
        rst = 1'b0;
        rx_valid = 1'b0;
        idle_bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            smii_txd = i[0] ^ i[2];
            tick();
            if (locked || smii_rxd || rx_ready || tx_valid || sync_err || tx_frame) idle_bad = 1'b1;
        end
        total++; if (idle_bad !== 1'b0) begin bad++; $display("FAIL postrst_idle got %b want 0", idle_bad); end
        b = tv_cnt;
        send_seg(txseg(8'h42, 1'b1, 1'b0), 10);
        send_seg(10'h000, 10);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL resync_locked got %b want 1", locked); end
        total++; if (tv_cnt - b !== 1) begin bad++; $display("FAIL resync_tx_pulses got %0d want 1", tv_cnt - b); end
        total++; if (tx_data !== 8'h42) begin bad++; $display("FAIL resync_tx_byte got %h want 42", tx_data); end
    endtask

    initial begin
        test_reset();
        test_idle_segment();
        test_tx_data();
        test_rx_data();
        test_rx_status();
        test_10m();
        test_misalign();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
